// File: rtl/sincos_ctrl_if.sv
// Handshake and core-side bundle for sincos_ctrl; the slave modport is the controller's view.
interface sincos_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        core_start;
    logic [31:0] core_x;
    logic        core_sel;
    logic        core_done;
    logic [31:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_timeout;
    logic [2:0]  fsm_state;

    modport slave (
        input  in_valid, in_data, in_sel, core_done, core_result, out_ready,
        output in_ready, core_start, core_x, core_sel, out_valid, out_data,
        output out_invalid, out_timeout, fsm_state
    );

    modport master (
        output in_valid, in_data, in_sel, core_done, core_result, out_ready,
        input  in_ready, core_start, core_x, core_sel, out_valid, out_data,
        input  out_invalid, out_timeout, fsm_state
    );
endinterface

// File: rtl/sincos_ctrl.sv
// sincos_ctrl: classifies an IEEE-754 operand, answers specials directly, sequences the sin/cos core.
// Optional core-response watchdog is built only when SINCOS_TIMEOUT_EN is defined.
module sincos_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic          clk,
    input logic          rst,
    sincos_ctrl_if.slave bus
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid, once raised, holds with stable data until that edge.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLASS = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;

    logic [2:0]  state;
    logic [31:0] x_q;
    logic        sel_q;
    logic [31:0] data_q;
    logic        invalid_q;
    logic        timeout_hit;
    logic        is_zero;
    logic        exp_ones;
    logic        frac_zero;

    assign is_zero   = (x_q[30:0] == 31'd0);
    assign exp_ones  = (x_q[30:23] == 8'hFF);
    assign frac_zero = (x_q[22:0] == 23'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            x_q       <= 32'd0;
            sel_q     <= 1'b0;
            data_q    <= 32'd0;
            invalid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_q   <= bus.in_data;
                        sel_q <= bus.in_sel;
                        state <= S_CLASS;
                    end
                end
                S_CLASS: begin
                    if (is_zero) begin
                        data_q    <= sel_q ? ONE : x_q;
                        invalid_q <= 1'b0;
                        state     <= S_DONE;
                    end else if (exp_ones && frac_zero) begin
                        data_q    <= QNAN;
                        invalid_q <= 1'b1;
                        state     <= S_DONE;
                    end else if (exp_ones) begin
                        // Quiet the NaN; only a signaling input raises invalid.
                        data_q    <= x_q | 32'h0040_0000;
                        invalid_q <= ~x_q[22];
                        state     <= S_DONE;
                    end else begin
                        state <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.core_done) begin
                        data_q    <= bus.core_result;
                        invalid_q <= 1'b0;
                        state     <= S_DONE;
                    end else if (timeout_hit) begin
                        data_q    <= QNAN;
                        invalid_q <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SINCOS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // The limit cycle is the TIMEOUT-th WAIT cycle; a core_done in that cycle still wins.
    assign timeout_hit = (state == S_WAIT) && !bus.core_done &&
                         (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_START) cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + 1'b1;
            if (state == S_CLASS) timeout_q <= 1'b0;
            else if (state == S_WAIT) timeout_q <= timeout_hit;
        end
    end

    assign bus.out_timeout = timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.out_timeout = 1'b0;
`endif

    assign bus.in_ready    = (state == S_IDLE);
    assign bus.core_start  = (state == S_START);
    assign bus.out_valid   = (state == S_DONE);
    assign bus.core_x      = x_q;
    assign bus.core_sel    = sel_q;
    assign bus.out_data    = data_q;
    assign bus.out_invalid = invalid_q;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_sincos_ctrl.sv
// Bench for sincos_ctrl: directed specials/normals/reset/backpressure, then randomized back-to-back traffic.
// Timeout scenarios run only when SINCOS_TIMEOUT_EN is defined for the whole compile.
module tb_sincos_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sincos_ctrl_if bus();

    sincos_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];  // {timeout, invalid, data}

    logic        model_done = 1'b0;
    logic [31:0] model_res  = 32'd0;
    logic        extra_done = 1'b0;
    logic [31:0] extra_res  = 32'd0;
    logic        ready_dir  = 1'b1;
    logic        ready_rnd  = 1'b1;
    bit          rand_ready = 1'b0;
    bit          rand_lat   = 1'b0;
    bit          core_silent = 1'b0;
    int          core_lat   = 3;

    bit          busy = 1'b0;
    bit          pending_normal = 1'b0;
    int          acc_cyc = -100;
    int          accepted = 0;
    int          starts = 0;
    logic [31:0] acc_x = 32'd0;
    logic        acc_sel = 1'b0;

    assign bus.core_done   = model_done | extra_done;
    assign bus.core_result = extra_done ? extra_res : model_res;
    assign bus.out_ready   = rand_ready ? ready_rnd : ready_dir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] core_fn(input logic [31:0] x, input logic sel);
        if (x == 32'h3F80_0000 && !sel) return 32'h3F57_6AA4;
        return sel ? (x ^ 32'hA5A5_A5A5) : {x[15:0], x[31:16]};
    endfunction

    function automatic bit is_special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:0] == 31'd0);
    endfunction

    // Result the controller must produce for an operand, straight from the classification rules.
    function automatic logic [33:0] model(input logic [31:0] x, input logic sel, input bit silent);
        if (x[30:0] == 31'd0) return {2'b00, (sel ? 32'h3F80_0000 : x)};
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) return {2'b01, 32'h7FC0_0000};
            return {1'b0, ~x[22], (x | 32'h0040_0000)};
        end
`ifdef SINCOS_TIMEOUT_EN
        if (silent) return {2'b10, 32'h7FC0_0000};
`endif
        return {2'b00, core_fn(x, sel)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 4))
            0: r[30:0] = 31'd0;
            1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            2: begin r[30:23] = 8'hFF; if (r[22:0] == 23'd0) r[0] = 1'b1; end
            default: if (is_special(r)) r[30:23] = 8'h40;
        endcase
        return r;
    endfunction

    // Compare process: in_ready, core_start timing and result stream every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", bus.in_ready, !busy);
            check("core_start", bus.core_start, pending_normal && (cyc == acc_cyc + 2));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", bus.out_valid, 1'b0);
                end else begin
                    check("result", {bus.out_timeout, bus.out_invalid, bus.out_data}, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data, bus.in_sel, core_silent));
                acc_x = bus.in_data;
                acc_sel = bus.in_sel;
                acc_cyc = cyc;
                accepted++;
                busy = 1'b1;
                pending_normal = !is_special(bus.in_data);
            end
        end
    end

    // Core model: answers each core_start after a chosen latency.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (!rst && bus.core_start) begin
                starts++;
                check("core_x", bus.core_x, acc_x);
                check("core_sel", bus.core_sel, acc_sel);
                if (!core_silent) begin
                    lat = rand_lat ? int'($urandom_range(1, 8)) : core_lat;
                    repeat (lat) @(posedge clk);
                    #1;
                    check("core_x_hold", bus.core_x, acc_x);
                    model_done = 1'b1;
                    model_res = core_fn(bus.core_x, bus.core_sel);
                    @(posedge clk);
                    #1 model_done = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 ready_rnd = ($urandom_range(0, 9) < 7);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [31:0] x, input logic sel, output int n);
        bus.in_valid = 1'b1;
        bus.in_data = x;
        bus.in_sel = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 400);
        check("accept", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({nm, " out_valid"}, bus.out_valid, 1'b1);
    endtask

    task automatic directed(input string nm, input logic [31:0] x, input logic sel,
                            input int lat_exp, input logic [31:0] d_exp, input logic inv_exp,
                            input logic tmo_exp);
        int n;
        int s0;
        s0 = starts;
        send(x, sel, n);
        wait_valid(nm);
        check({nm, " latency"}, cyc - acc_cyc, lat_exp);
        check({nm, " data"}, bus.out_data, d_exp);
        check({nm, " invalid"}, bus.out_invalid, inv_exp);
        check({nm, " timeout"}, bus.out_timeout, tmo_exp);
        if (lat_exp == 2) check({nm, " starts"}, starts - s0, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.core_start && n < 50);
        check({nm, " core_start"}, bus.core_start, 1'b1);
        check({nm, " start cycle"}, cyc - acc_cyc, 2);
    endtask

    initial begin
        int n;
        int acc0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'd0;
        bus.in_sel = 1'b0;

        #2;
        check("rst in_ready", bus.in_ready, 1'b1);
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst core_start", bus.core_start, 1'b0);
        check("rst out_data", bus.out_data, 32'd0);
        check("rst out_invalid", bus.out_invalid, 1'b0);
        check("rst out_timeout", bus.out_timeout, 1'b0);
        check("rst core_x", bus.core_x, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        directed("sin -0", 32'h8000_0000, 1'b0, 2, 32'h8000_0000, 1'b0, 1'b0);
        directed("cos +0", 32'h0000_0000, 1'b1, 2, 32'h3F80_0000, 1'b0, 1'b0);
        directed("sin inf", 32'h7F80_0000, 1'b0, 2, 32'h7FC0_0000, 1'b1, 1'b0);
        directed("cos snan", 32'h7F80_0001, 1'b1, 2, 32'h7FC0_0001, 1'b1, 1'b0);
        directed("sin qnan", 32'hFFC0_0005, 1'b0, 2, 32'hFFC0_0005, 1'b0, 1'b0);

        core_lat = 20;
        fork
            directed("sin 1.0", 32'h3F80_0000, 1'b0, 23, 32'h3F57_6AA4, 1'b0, 1'b0);
            begin
                @(posedge clk);
                #1;
                wait_start("sin 1.0");
                check("sin 1.0 core_x", bus.core_x, 32'h3F80_0000);
                check("sin 1.0 core_sel", bus.core_sel, 1'b0);
            end
        join
        core_lat = 3;
        directed("cos 2.0", 32'h4000_0000, 1'b1, 6, 32'h4000_0000 ^ 32'hA5A5_A5A5, 1'b0, 1'b0);

        // Backpressure with stray core_done pulses while the result is held.
        ready_dir = 1'b0;
        send(32'h0000_0000, 1'b1, n);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            extra_done = (i % 2 == 0);
            extra_res = $urandom();
        end
        @(posedge clk);
        #1 extra_done = 1'b0;
        @(negedge clk);
        check("bp held valid", bus.out_valid, 1'b1);
        check("bp held data", bus.out_data, 32'h3F80_0000);
        check("bp in_ready", bus.in_ready, 1'b0);
        ready_dir = 1'b1;
        @(posedge clk);
        #1;

`ifdef SINCOS_TIMEOUT_EN
        core_silent = 1'b1;
        directed("tmo silent", 32'h4049_0FDB, 1'b0, 11, 32'h7FC0_0000, 1'b0, 1'b1);
        core_silent = 1'b0;
        core_lat = 8;
        directed("tmo edge", 32'h4049_0FDB, 1'b0, 11, core_fn(32'h4049_0FDB, 1'b0), 1'b0, 1'b0);
        core_lat = 3;
`endif

        // Asynchronous reset in the middle of WAIT.
        core_silent = 1'b1;
        send(32'h4049_0FDB, 1'b1, n);
        wait_start("rst op");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async in_ready", bus.in_ready, 1'b1);
        check("async core_start", bus.core_start, 1'b0);
        check("async out_valid", bus.out_valid, 1'b0);
        check("async out_data", bus.out_data, 32'd0);
        check("async out_invalid", bus.out_invalid, 1'b0);
        check("async out_timeout", bus.out_timeout, 1'b0);
        check("async core_x", bus.core_x, 32'd0);
        check("async core_sel", bus.core_sel, 1'b0);
        exp_q.delete();
        busy = 1'b0;
        pending_normal = 1'b0;
        core_silent = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(32'hBF00_0000, 1'b0, n);
        check("post-rst first offer", n, 1);
        wait_valid("post-rst");
        @(posedge clk);
        #1;

        // Back-to-back randomized traffic with in_valid held high.
        rand_lat = 1'b1;
        rand_ready = 1'b1;
        acc0 = accepted;
        bus.in_valid = 1'b1;
        bus.in_data = rand_op();
        bus.in_sel = 1'($urandom_range(0, 1));
        for (int i = 0; i < 80; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.in_ready && n < 400);
            @(posedge clk);
            #1;
            bus.in_data = rand_op();
            bus.in_sel = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("b2b accepted", accepted - acc0, 80);
        check("b2b drained", exp_q.size(), 0);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
